// File: rtl/bus_arbiter_32_if.sv
// Bus arbiter handshake bundle: request vector and owner release in,
// one-hot grant, owner index, valid flag and preempt pulse out.
interface bus_arbiter_32_if;
  logic [31:0] i_req;
  logic        i_release;
  logic [31:0] o_grant;
  logic        o_grant_valid;
  logic [4:0]  o_grant_id;
  logic        o_preempt;

  // Arbiter side
  modport slave (
    input  i_req, i_release,
    output o_grant, o_grant_valid, o_grant_id, o_preempt
  );

  // Requester side
  modport master (
    output i_req, i_release,
    input  o_grant, o_grant_valid, o_grant_id, o_preempt
  );
endinterface

// File: rtl/bus_arbiter_32.sv
// 32-source round-robin bus arbiter with hold-time limit.
// An owner keeps the bus until it pulses release or has held it HOLD_MAX
// cycles; either way one idle (grant=0) turnaround cycle follows before the
// next grant, so drivers never overlap. The search pointer moves one past
// the last owner so sources are served fairly.
module bus_arbiter_32 #(
  parameter int unsigned HOLD_MAX = 16  // legal 1..255
) (
  input  logic             i_clock,
  input  logic             i_clear,
  bus_arbiter_32_if.slave  bus
);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t      r_state;
  logic [31:0] r_grant;
  logic [4:0]  r_grant_id;
  logic        r_grant_valid;
  logic        r_preempt;
  logic [4:0]  r_ptr;
  logic [7:0]  r_hold;

  logic        w_found;
  logic [4:0]  w_sel;
  logic [4:0]  w_idx;
  logic [4:0]  w_next_ptr;
  logic        w_expire;

  // First set request at or above the pointer, wrapping 31 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 5'd0;
    w_idx   = 5'd0;
    for (int k = 0; k < 32; k++) begin
      w_idx = r_ptr + 5'(k);
      if (!w_found && bus.i_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Pointer after the current owner leaves; 5-bit add wraps 31 -> 0.
  assign w_next_ptr = r_grant_id + 5'd1;
  // Hold counter already includes the grant cycle, so equality means the
  // owner has had its full HOLD_MAX cycles.
  assign w_expire   = (r_hold == HOLD_LIM);

  // Arbitration FSM; every output is a register.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_preempt     <= 1'b0;
      r_ptr         <= '0;
      r_hold        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // release is meaningless without an owner and is ignored here
          r_preempt <= 1'b0;
          if (w_found) begin
            r_state       <= S_OWNED;
            r_grant       <= 32'd1 << w_sel;
            r_grant_id    <= w_sel;
            r_grant_valid <= 1'b1;
            r_hold        <= 8'd1;
          end else begin
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_hold        <= '0;
          end
        end
        S_OWNED: begin
          if (bus.i_release || w_expire) begin
            // release wins over a simultaneous expiry: no preempt pulse
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= w_next_ptr;
            r_hold        <= '0;
            r_preempt     <= !bus.i_release;
          end else begin
            r_hold    <= r_hold + 8'd1;
            r_preempt <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant       <= '0;
          r_grant_id    <= '0;
          r_grant_valid <= 1'b0;
          r_preempt     <= 1'b0;
          r_hold        <= '0;
        end
      endcase
    end
  end

  assign bus.o_grant       = r_grant;
  assign bus.o_grant_id    = r_grant_id;
  assign bus.o_grant_valid = r_grant_valid;
  assign bus.o_preempt     = r_preempt;

endmodule

// File: tb/tb_bus_arbiter_32.sv
// Bench for bus_arbiter_32: directed vector table, hand-written hold-expiry
// sequences, then random traffic against a behavioural owner/pointer model.
module tb_bus_arbiter_32;

  localparam int HOLD = 16;

  logic clk;
  logic clr;
  bus_arbiter_32_if bus();

  bus_arbiter_32 #(.HOLD_MAX(HOLD)) dut (
    .i_clock (clk),
    .i_clear (clr),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, how long, where the search starts.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_pre   = 0;

  function automatic void model_edge(bit c, logic [31:0] r, bit rel);
    if (c) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_pre = 0;
    end else if (m_owner < 0) begin
      m_pre = 0;
      for (int off = 0; off < 32; off++) begin
        int j;
        j = (m_ptr + off) % 32;
        if (r[j]) begin
          m_owner = j; m_cnt = 1;
          break;
        end
      end
    end else if (rel) begin
      m_ptr = (m_owner + 1) % 32; m_owner = -1; m_pre = 0;
    end else if (m_cnt == HOLD) begin
      m_ptr = (m_owner + 1) % 32; m_owner = -1; m_pre = 1;
    end else begin
      m_cnt = m_cnt + 1; m_pre = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare after.
  task automatic step(input bit c, input logic [31:0] r, input bit rel);
    logic [31:0] eg;
    @(negedge clk);
    clr = c; bus.i_req = r; bus.i_release = rel;
    @(posedge clk);
    model_edge(c, r, rel);
    #1;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("model_grant",   bus.o_grant, eg);
    chk("model_id",      32'(bus.o_grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_valid",   32'(bus.o_grant_valid), 32'(m_owner >= 0));
    chk("model_preempt", 32'(bus.o_preempt), 32'(m_pre));
    n_tests++;
    if ($countones(bus.o_grant) > 1 || bus.o_grant_valid !== (bus.o_grant != 0)) begin
      n_fail++;
      $display("FAIL onehot @%0t: got grant %h valid %b, required one-hot and valid==(grant!=0)",
               $time, bus.o_grant, bus.o_grant_valid);
    end
  endtask

  typedef struct {
    bit          c;
    logic [31:0] r;
    bit          rel;
    logic [31:0] g;
    logic [4:0]  id;
    bit          gv;
    bit          pre;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit c, logic [31:0] r, bit rel,
                              logic [31:0] g, logic [4:0] id, bit gv, bit pre);
    vec_t v;
    v.c = c; v.r = r; v.rel = rel; v.g = g; v.id = id; v.gv = gv; v.pre = pre;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] rr;
    bit          rl;
    clr = 1'b1; bus.i_req = '0; bus.i_release = 1'b0;

    //   clr req           rel  grant         id  gv pre
    add(1, 32'h0000_0000, 0, 32'h0000_0000, 0,  0, 0); // reset state
    add(0, 32'h0000_0005, 0, 32'h0000_0001, 0,  1, 0); // first search from bit 0
    add(0, 32'h0000_0005, 1, 32'h0000_0000, 0,  0, 0); // release -> idle
    add(0, 32'h0000_0005, 0, 32'h0000_0004, 2,  1, 0); // rotated to source 2
    add(0, 32'h0000_0005, 0, 32'h0000_0004, 2,  1, 0); // held
    add(0, 32'h0000_0000, 0, 32'h0000_0004, 2,  1, 0); // owner drops req, still held
    add(0, 32'h0000_0000, 1, 32'h0000_0000, 0,  0, 0); // release
    add(0, 32'h0000_0000, 1, 32'h0000_0000, 0,  0, 0); // release in idle ignored
    add(0, 32'h4000_0000, 0, 32'h4000_0000, 30, 1, 0);
    add(0, 32'h0000_0000, 1, 32'h0000_0000, 0,  0, 0); // ptr -> 31
    add(0, 32'h8000_0001, 0, 32'h8000_0000, 31, 1, 0); // search from 31
    add(0, 32'h8000_0001, 1, 32'h0000_0000, 0,  0, 0); // ptr wraps to 0
    add(0, 32'h8000_0001, 0, 32'h0000_0001, 0,  1, 0); // wrap grant
    add(0, 32'h0001_0000, 1, 32'h0000_0000, 0,  0, 0); // new req in release cycle
    add(0, 32'h0001_0000, 0, 32'h0001_0000, 16, 1, 0);
    add(1, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0,  0, 0); // clear mid-ownership wins
    add(0, 32'hFFFF_FFFF, 0, 32'h0000_0001, 0,  1, 0); // search restarts at 0
    add(1, 32'h0000_0000, 0, 32'h0000_0000, 0,  0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].r, tbl[i].rel);
      chk($sformatf("vec%0d_grant", i), bus.o_grant, tbl[i].g);
      chk($sformatf("vec%0d_id", i), 32'(bus.o_grant_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d_valid", i), 32'(bus.o_grant_valid), 32'(tbl[i].gv));
      chk($sformatf("vec%0d_preempt", i), 32'(bus.o_preempt), 32'(tbl[i].pre));
    end

    // Hold expiry: exactly HOLD grant cycles, one preempt idle, re-grant.
    for (int i = 0; i < HOLD; i++) begin
      step(0, 32'h0000_0100, 0);
      chk($sformatf("hold_grant%0d", i), bus.o_grant, 32'h0000_0100);
      chk($sformatf("hold_pre%0d", i), 32'(bus.o_preempt), 32'd0);
    end
    step(0, 32'h0000_0100, 0);
    chk("expire_grant", bus.o_grant, 32'd0);
    chk("expire_preempt", 32'(bus.o_preempt), 32'd1);
    step(0, 32'h0000_0100, 0);
    chk("regrant_grant", bus.o_grant, 32'h0000_0100);
    chk("regrant_id", 32'(bus.o_grant_id), 32'd8);
    chk("regrant_preempt", 32'(bus.o_preempt), 32'd0);

    // Release landing on the expiry cycle: plain release, no preempt.
    for (int i = 1; i < HOLD; i++) step(0, 32'h0000_0100, 0);
    chk("pre_tie_grant", bus.o_grant, 32'h0000_0100);
    step(0, 32'h0000_0100, 1);
    chk("tie_grant", bus.o_grant, 32'd0);
    chk("tie_preempt", 32'(bus.o_preempt), 32'd0);

    // Random traffic against the model.
    step(1, 32'd0, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rr = 32'd0;
        1: rr = 32'd1 << $urandom_range(0, 31);
        2: rr = $urandom & $urandom & $urandom;
        default: rr = $urandom;
      endcase
      rl = ($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 199) == 0), rr, rl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
